// File: rtl/rh_bf_in_cond.sv
// Input conditioning ahead of the TinyBF core: pad synchronisers, UART RX
// majority filter, control-pin debouncers and start/halt pulse generation.
module rh_bf_in_cond #(
  parameter int unsigned DEB_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] pad_i,
  output logic [3:0] ui_o
);

  localparam int unsigned CW       = $clog2(DEB_CYCLES + 1);
  localparam int unsigned N_DEB    = 3;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [3:0]  SYNC_RST = 4'b0001;

  // Debounced channel index: 0 = start, 1 = halt, 2 = prog mode
  localparam int unsigned CH_START = 0;
  localparam int unsigned CH_HALT  = 1;
  localparam int unsigned CH_PROG  = 2;

  logic [3:0]          r_s1;
  logic [3:0]          r_s2;
  logic [2:0]          r_rx_hist;
  logic                r_rx;
  logic [N_DEB-1:0]    r_stb;
  logic [CW-1:0]       r_cnt [N_DEB];
  logic                r_start_pls;
  logic                r_halt_pls;

  logic [N_DEB-1:0]    w_stb_nxt;
  logic [CW-1:0]       w_cnt_nxt [N_DEB];
  logic                w_rx_maj;
  logic                w_start_rise;
  logic                w_halt_rise;
  logic                w_start_pls_nxt;

  // Two-flop synchronisers; RX idles high so bit 0 resets to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= SYNC_RST;
      r_s2 <= SYNC_RST;
    end else begin
      r_s1 <= pad_i;
      r_s2 <= r_s1;
    end
  end

  assign w_rx_maj = (r_rx_hist[0] & r_rx_hist[1]) |
                    (r_rx_hist[1] & r_rx_hist[2]) |
                    (r_rx_hist[0] & r_rx_hist[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_hist <= 3'b111;
      r_rx      <= 1'b1;
    end else begin
      r_rx_hist <= {r_rx_hist[1:0], r_s2[0]};
      r_rx      <= w_rx_maj;
    end
  end

  // Debouncer next state: any cycle agreeing with stb restarts qualification
  always_comb begin
    w_stb_nxt = r_stb;
    for (int i = 0; i < N_DEB; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_s2[i+1] != r_stb[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_stb_nxt[i] = r_s2[i+1];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stb <= '0;
      for (int i = 0; i < N_DEB; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_stb <= w_stb_nxt;
      for (int i = 0; i < N_DEB; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  // Pulses align with the stb rise; interlocks look at the post-edge levels
  assign w_start_rise    = w_stb_nxt[CH_START] & ~r_stb[CH_START];
  assign w_halt_rise     = w_stb_nxt[CH_HALT]  & ~r_stb[CH_HALT];
  assign w_start_pls_nxt = w_start_rise & ~w_stb_nxt[CH_PROG] & ~w_stb_nxt[CH_HALT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_pls <= 1'b0;
      r_halt_pls  <= 1'b0;
    end else begin
      r_start_pls <= w_start_pls_nxt;
      r_halt_pls  <= w_halt_rise;
    end
  end

  assign ui_o = {r_stb[CH_PROG], r_halt_pls, r_start_pls, r_rx};

endmodule

// File: tb/tb_rh_bf_in_cond.sv
// Directed bench for rh_bf_in_cond with DEB_CYCLES=4; edge numbers count
// rising edges after the pad change, outputs sampled 1 ns after each edge.
module tb_rh_bf_in_cond;

  localparam int unsigned DEB = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] pad_i;
  logic [3:0] ui_o;

  int n_total;
  int n_pass;
  int n_fail;

  rh_bf_in_cond #(.DEB_CYCLES(DEB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pad_i (pad_i),
    .ui_o  (ui_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {3'b000, obs}, {3'b000, exp});
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    pad_i   = 4'b0001;

    repeat (3) step();
    chk("reset_value", ui_o, 4'b0001);
    rst_n = 1'b1;

    // Idle pads
    for (int e = 1; e <= 100; e++) begin
      step();
      chk("idle", ui_o, 4'b0001);
    end

    // Start held 20 cycles: one pulse on edge 6
    pad_i = 4'b0011;
    for (int e = 1; e <= 20; e++) begin
      step();
      chk1($sformatf("start_hold_e%0d", e), ui_o[1], logic'(e == 6));
    end
    pad_i = 4'b0001;
    repeat (10) step();
    chk("start_released", ui_o, 4'b0001);

    // Start bouncing: high 3, low 1, high 3
    for (int e = 1; e <= 15; e++) begin
      pad_i = ((e <= 3) || (e >= 5 && e <= 7)) ? 4'b0011 : 4'b0001;
      step();
      chk1($sformatf("bounce_e%0d", e), ui_o[1], 1'b0);
    end
    repeat (5) step();

    // Prog mode level, then start suppressed while prog is set
    pad_i = 4'b1001;
    for (int e = 1; e <= 8; e++) begin
      step();
      chk1($sformatf("prog_e%0d", e), ui_o[3], logic'(e >= 6));
    end
    pad_i = 4'b1011;
    for (int e = 1; e <= 20; e++) begin
      if (e == 11) pad_i = 4'b1001;
      step();
      chk1($sformatf("start_in_prog_e%0d", e), ui_o[1], 1'b0);
    end
    pad_i = 4'b0001;
    repeat (10) step();
    chk("prog_released", ui_o, 4'b0001);

    // Start and halt together: halt wins
    pad_i = 4'b0111;
    for (int e = 1; e <= 12; e++) begin
      step();
      chk1($sformatf("both_halt_e%0d", e), ui_o[2], logic'(e == 6));
      chk1($sformatf("both_start_e%0d", e), ui_o[1], 1'b0);
    end
    pad_i = 4'b0001;
    repeat (10) step();
    chk("both_released", ui_o, 4'b0001);

    // RX single-cycle glitch is filtered
    pad_i = 4'b0000;
    for (int e = 1; e <= 10; e++) begin
      step();
      pad_i = 4'b0001;
      chk1($sformatf("rx_glitch_e%0d", e), ui_o[0], 1'b1);
    end

    // RX low for 3 cycles: low on edges 5..7
    for (int e = 1; e <= 10; e++) begin
      pad_i = (e <= 3) ? 4'b0000 : 4'b0001;
      step();
      chk1($sformatf("rx_low3_e%0d", e), ui_o[0], logic'(!(e >= 5 && e <= 7)));
    end
    repeat (5) step();

    // Reset mid halt qualification with RX low so ui_o is non-idle first
    pad_i = 4'b0100;
    repeat (5) step();
    chk("pre_reset", ui_o, 4'b0000);
    rst_n = 1'b0;
    #1;
    chk("async_reset", ui_o, 4'b0001);
    pad_i = 4'b0101;
    repeat (3) step();
    chk("held_in_reset", ui_o, 4'b0001);
    rst_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      chk1($sformatf("post_reset_halt_e%0d", e), ui_o[2], logic'(e == 6));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rh_bf_in_cond.md
RH_BF_IN_COND -- requirements
Module: rh_bf_in_cond

Input-conditioning stage placed directly upstream of the TinyBF core's dedicated inputs. It synchronises the raw board pads, glitch-filters UART RX, debounces the control pins, and turns start/halt into single-cycle pulses.

Interface
REQ-001 Parameter DEB_CYCLES, default 250000, is the number of consecutive synchronised cycles a control-pin level must hold before it is accepted (10 ms at 25 MHz); legal range is 1 or more.
REQ-002 The counter width SHALL be $clog2(DEB_CYCLES+1), derived internally and not overridable.
REQ-003 clk  input  1  single system clock; all state is on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 pad_i  input  4  raw asynchronous board pins: [0] UART RX, [1] start button, [2] halt button, [3] prog-mode switch.
REQ-006 ui_o  output  4  conditioned bits, fed bit-for-bit to the core's ui_in: [0] filtered RX, [1] start pulse, [2] halt pulse, [3] debounced prog mode.
REQ-007 All ui_o bits SHALL be driven directly from flip-flops, with no combinational path from pad_i.

Function
REQ-008 Each pad_i bit SHALL pass through a dedicated 2-flop synchroniser (s1 then s2) before any other logic.
REQ-009 RX filter:
- a 3-bit history register shifts in s2 every cycle;
- ui_o[0] is registered as the 2-of-3 majority of the history;
- a synchronised RX level that is stable for 2 or more cycles SHALL appear on ui_o[0] exactly 5 rising edges after the pad change;
- a synchronised RX glitch 1 cycle wide SHALL never appear on ui_o[0].
REQ-010 Channels 1..3 SHALL each have an independent debouncer with an accepted level stb and a counter cnt.
REQ-011 Debouncer rules, evaluated each cycle:
- s2 equal to stb: cnt clears to 0;
- s2 differs from stb and cnt < DEB_CYCLES-1: cnt increments;
- s2 differs from stb and cnt == DEB_CYCLES-1: stb takes s2 and cnt clears.
REQ-012 Any single cycle where s2 equals stb SHALL restart the qualification count from zero.
REQ-013 A pad level held long enough SHALL change stb on rising edge 2+DEB_CYCLES after the pad change (DEB_CYCLES=1 gives edge 3).
REQ-014 ui_o[3] SHALL equal stb of channel 3, a level with no pulse shaping.
REQ-015 ui_o[2] SHALL be high for exactly one cycle, registered on the same edge at which halt stb goes 0 to 1.
REQ-016 ui_o[1] SHALL be high for exactly one cycle, registered on the same edge at which start stb goes 0 to 1, unless an interlock in REQ-017 or REQ-018 applies.
REQ-017 Start pulse suppression:
- suppressed when the prog-mode stb is 1 in the cycle the start stb rises, including a prog-mode stb that rises on that same edge;
- suppressed when the halt stb is 1 in that cycle.
REQ-018 If start and halt stb rise on the same edge, only the halt pulse SHALL be emitted; halt has priority.
REQ-019 A start or halt rise that was suppressed SHALL NOT be replayed later. A new pulse requires the stb to fall and rise again.
REQ-020 Falling edges of start/halt stb SHALL produce no pulse.
REQ-021 Holding a button high indefinitely SHALL produce exactly one pulse.

Reset
REQ-022 While rst_n=0, and immediately on its assertion without waiting for clk, all state SHALL clear.
REQ-023 Reset values:
- synchroniser flops for bit 0 and the RX history reset to 1 (UART idle);
- all other synchroniser flops, every stb and every cnt reset to 0;
- ui_o therefore resets to 4'b0001.
REQ-024 Reset asserted mid-qualification SHALL discard the partial count.
REQ-025 A button still held high when rst_n deasserts SHALL requalify from 0 and then emit one pulse at edge 2+DEB_CYCLES after release of reset.

Verification
REQ-026 The bench SHALL use DEB_CYCLES=4 for all scenarios below.
REQ-027 Reset then idle pads (pad_i=4'b0001): ui_o stays 4'b0001 for 100 cycles.
REQ-028 pad_i[1] raised and held 20 cycles: ui_o[1]=1 on edge 6 only, 0 for the rest.
REQ-029 pad_i[1] toggled high 3 cycles, low 1, high 3: no start pulse, and ui_o[1] stays 0.
REQ-030 Interlocks:
- pad_i[3] held high (ui_o[3]=1 from edge 6), then pad_i[1] pulsed 10 cycles: ui_o[1] stays 0;
- pad_i[1] and pad_i[2] raised on the same cycle: ui_o[2] pulses at edge 6 and ui_o[1] stays 0.
REQ-031 pad_i[0]:
- 1-cycle low pulse on synchronised RX: ui_o[0] stays 1;
- a 0 held 3 cycles: ui_o[0] falls on edge 5.
REQ-032 rst_n pulsed low at cycle 3 of a pad_i[2] qualification, pad held: ui_o=4'b0001 asynchronously, then ui_o[2] pulses once at edge 6 after reset release.
